// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// regfile_dump : walks a register mask in ascending order and streams each
//                register value with its index over valid/ready.
// Revision     : 1.0
// ============================================================================
module regfile_dump #(
  parameter int N    = 16,
  parameter int NREG = 8,
  parameter int RW   = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [NREG-1:0] mask,
  output logic [RW-1:0]   readnum,
  input  logic [N-1:0]    rf_data,
  output logic [N-1:0]    out_data,
  output logic [RW-1:0]   out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREG-1:0] pend_mask_q, pend_mask_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic [RW-1:0]   out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d;
  logic [RW-1:0]   cur_idx;
  logic [NREG-1:0] pend_clr;

  // Descending scan so the last hit, and therefore the winner, is the lowest set bit.
  always_comb begin
    cur_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (pend_mask_q[i]) cur_idx = RW'(i);
    end
  end

  assign pend_clr = pend_mask_q & ~(NREG'(1) << out_idx_q);

  always_comb begin
    state_d     = state_q;
    pend_mask_d = pend_mask_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    readnum     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (mask != '0) begin
            pend_mask_d = mask;
            state_d     = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        readnum     = cur_idx;
        out_data_d  = rf_data;
        out_idx_d   = cur_idx;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        readnum = out_idx_q;
        if (out_ready) begin
          pend_mask_d = pend_clr;
          out_valid_d = 1'b0;
          state_d     = (pend_clr == '0) ? DONE : FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_mask_q <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_mask_q <= pend_mask_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// tb_regfile_dump : directed and randomized dumps checked against a snapshot
//                   model of the register file contents.
// Revision        : 1.0
// ============================================================================
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  mask;
  logic [2:0]  readnum;
  logic [15:0] rf_data;
  logic [15:0] out_data;
  logic [2:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] rf [8];
  logic [15:0] model_rf [8];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (we) rf[waddr] <= wdata;
  end
  assign rf_data = rf[readnum];

  regfile_dump #(.N(16), .NREG(8), .RW(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mask      (mask),
    .readnum   (readnum),
    .rf_data   (rf_data),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input int idx, input logic [15:0] d);
    we    = 1'b1;
    waddr = 3'(idx);
    wdata = d;
    step();
    we = 1'b0;
    model_rf[idx] = d;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 five stall cycles on beat 0
  task automatic run_dump(input logic [7:0] m, input int rmode, input bit poke_start,
                          input int race_idx);
    int          q_idx[$];
    logic [15:0] q_dat[$];
    int          cyc, last_hs, beats, n_beats, stall;
    bit          seen_done, seen_valid, raced;
    logic [15:0] sd;
    logic [2:0]  si;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        q_idx.push_back(i);
        q_dat.push_back(model_rf[i]);
      end
    end
    n_beats    = q_idx.size();
    start      = 1'b1;
    mask       = m;
    out_ready  = 1'b0;
    step();
    start      = 1'b0;
    mask       = 8'($urandom);
    cyc        = 1;
    last_hs    = -10;
    beats      = 0;
    stall      = 0;
    seen_done  = 1'b0;
    seen_valid = 1'b0;
    raced      = 1'b0;
    sd         = '0;
    si         = '0;
    while (!seen_done && cyc < 200) begin
      we = 1'b0;
      if (done) begin
        seen_done = 1'b1;
        chk("beats_sent", beats, n_beats);
        chk("done_timing", cyc, (n_beats == 0) ? 1 : last_hs + 1);
        chk("done_valid_low", {31'b0, out_valid}, 0);
        start = 1'b0;
      end else begin
        chk("busy_high", {31'b0, busy}, 1);
        if (out_valid) begin
          if (!seen_valid) chk("first_valid_lat", cyc, 2);
          seen_valid = 1'b1;
          chk("beat_in_range", {31'b0, beats < n_beats}, 1);
          if (q_idx.size() > 0) begin
            chk("beat_idx", {29'b0, out_idx}, q_idx[0]);
            chk("beat_data", {16'b0, out_data}, {16'b0, q_dat[0]});
          end
          chk("readnum_send", {29'b0, readnum}, {29'b0, out_idx});
          if (rmode == 2 && beats == 0 && stall < 5) begin
            if (stall > 0) begin
              chk("stall_data", {16'b0, out_data}, {16'b0, sd});
              chk("stall_idx", {29'b0, out_idx}, {29'b0, si});
            end
            stall++;
            out_ready = 1'b0;
          end else begin
            out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (out_ready) begin
            if (rmode == 0 && last_hs >= 0) chk("beat_spacing", cyc - last_hs, 2);
            last_hs = cyc;
            beats++;
            if (q_idx.size() > 0) begin
              void'(q_idx.pop_front());
              void'(q_dat.pop_front());
            end
          end
          sd = out_data;
          si = out_idx;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
          if (race_idx >= 0 && !raced && busy && readnum == 3'(race_idx)) begin
            raced = 1'b1;
            we    = 1'b1;
            waddr = 3'(race_idx);
            wdata = 16'hAAAA;
            model_rf[race_idx] = 16'hAAAA;
          end
        end
        if (poke_start) begin
          start = 1'($urandom_range(0, 1));
          mask  = 8'($urandom);
        end
      end
      step();
      cyc++;
    end
    if (!seen_done) chk("done_timeout", {31'b0, seen_done}, 1);
    we        = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    chk("busy_after_done", {31'b0, busy}, 0);
    chk("done_one_cycle", {31'b0, done}, 0);
    chk("readnum_idle", {29'b0, readnum}, 0);
  endtask

  initial begin
    bit found;
    reset_n   = 1'b0;
    start     = 1'b0;
    mask      = '0;
    out_ready = 1'b0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    for (int i = 0; i < 8; i++) model_rf[i] = '0;
    step();
    step();
    chk("rst_readnum", {29'b0, readnum}, 0);
    chk("rst_out_data", {16'b0, out_data}, 0);
    chk("rst_out_idx", {29'b0, out_idx}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    for (int i = 0; i < 8; i++) write_reg(i, 16'h1000 + 16'(i));
    reset_n = 1'b1;
    step();

    run_dump(8'hFF, 0, 1'b0, -1);
    run_dump(8'b1010_0100, 0, 1'b0, -1);
    run_dump(8'h03, 2, 1'b0, -1);
    run_dump(8'h00, 0, 1'b0, -1);
    run_dump(8'hFF, 0, 1'b1, -1);

    write_reg(3, 16'hBEEF);
    start = 1'b1;
    mask  = 8'hFF;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (out_valid && out_idx == 3'd3) begin
        found = 1'b1;
      end else begin
        out_ready = 1'b1;
        step();
      end
    end
    chk("reach_beat3", {31'b0, found}, 1);
    out_ready = 1'b0;
    reset_n   = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midrst_valid", {31'b0, out_valid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_data", {16'b0, out_data}, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_no_done", {31'b0, done | busy}, 0);
    end
    run_dump(8'h08, 0, 1'b0, -1);

    write_reg(4, 16'h5555);
    run_dump(8'hFF, 0, 1'b0, 4);
    run_dump(8'h10, 0, 1'b0, -1);

    for (int k = 0; k < 10; k++) begin
      write_reg(int'($urandom_range(0, 7)), 16'($urandom));
      run_dump(8'($urandom), 1, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
